keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 143 ++++++++++++++
 tb/tb_keypad_scanner.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates a one-hot row drive, debounces a single
// closed contact on press and release, and reports the held key with a press strobe.
module keypad_scanner #(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic [3:0] columns,
  output logic [3:0] rows,
  output logic [7:0] cur_key,
  output logic       strobe
);

  localparam int SLOT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_DONE  = DEB_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [3:0]        col_meta_r, scol_r;
  logic [SLOT_W-1:0] slot_r, slot_s;
  logic [DEB_W-1:0]  cnt_r, cnt_s;
  logic [3:0]        rows_r, rows_s;
  logic [7:0]        cand_r, cand_s;
  logic [7:0]        cur_key_r, cur_key_s;
  logic              strobe_r, strobe_s;

  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [3:0] next_row(input logic [3:0] v);
    return {v[0], v[3:1]};
  endfunction

  // Two-flop synchronizer for the raw column sense lines.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      col_meta_r <= 4'd0;
      scol_r     <= 4'd0;
    end else begin
      col_meta_r <= columns;
      scol_r     <= col_meta_r;
    end
  end

  // Next-state and next-output logic; cnt_s doubles as press and release counter.
  always_comb begin
    state_s   = state_r;
    slot_s    = slot_r;
    cnt_s     = cnt_r;
    rows_s    = rows_r;
    cand_s    = cand_r;
    cur_key_s = cur_key_r;
    strobe_s  = 1'b0;
    case (state_r)
      SCAN: begin
        if (slot_r == SLOT_LAST) begin
          slot_s = SLOT_W'(0);
          cnt_s  = DEB_W'(0);
          if (is_one_hot(scol_r)) begin
            cand_s  = {rows_r, scol_r};
            state_s = DEBOUNCE;
          end else begin
            rows_s = next_row(rows_r);
          end
        end else begin
          slot_s = slot_r + SLOT_W'(1);
        end
      end
      DEBOUNCE: begin
        if (scol_r != cand_r[3:0]) begin
          state_s = SCAN;
          slot_s  = SLOT_W'(0);
          cnt_s   = DEB_W'(0);
          rows_s  = next_row(rows_r);
        end else if (cnt_r == DEB_DONE) begin
          state_s   = HELD;
          cnt_s     = DEB_W'(0);
          cur_key_s = cand_r;
          strobe_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + DEB_W'(1);
        end
      end
      HELD: begin
        // Any contact on the frozen row, even another column, restarts release timing.
        if (scol_r != 4'd0) begin
          cnt_s = DEB_W'(0);
        end else if (cnt_r == DEB_DONE) begin
          state_s   = SCAN;
          slot_s    = SLOT_W'(0);
          cnt_s     = DEB_W'(0);
          cur_key_s = 8'd0;
          rows_s    = next_row(rows_r);
        end else begin
          cnt_s = cnt_r + DEB_W'(1);
        end
      end
      default: begin
        state_s   = SCAN;
        slot_s    = SLOT_W'(0);
        cnt_s     = DEB_W'(0);
        rows_s    = 4'b1000;
        cand_s    = 8'd0;
        cur_key_s = 8'd0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_r   <= SCAN;
      slot_r    <= SLOT_W'(0);
      cnt_r     <= DEB_W'(0);
      rows_r    <= 4'b1000;
      cand_r    <= 8'd0;
      cur_key_r <= 8'd0;
      strobe_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      slot_r    <= slot_s;
      cnt_r     <= cnt_s;
      rows_r    <= rows_s;
      cand_r    <= cand_s;
      cur_key_r <= cur_key_s;
      strobe_r  <= strobe_s;
    end
  end

  assign rows    = rows_r;
  assign cur_key = cur_key_r;
  assign strobe  = strobe_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives columns from rows and
// the pressed-key matrix; results are compared against hand-computed values.
module tb_keypad_scanner;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        Rst;
  logic [3:0]  columns;
  logic [3:0]  rows;
  logic [7:0]  cur_key;
  logic        strobe;
  logic [15:0] pressed;   // bit r*4+c = key RrCc closed

  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0;
  int   n;
  bit   found;
  logic [3:0] v;

  keypad_scanner dut (
    .clk     (clk),
    .Rst     (Rst),
    .columns (columns),
    .rows    (rows),
    .cur_key (cur_key),
    .strobe  (strobe)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a closed key shows its column only while its row is driven.
  always_comb begin
    columns = 4'd0;
    for (int r = 0; r < 4; r++) begin
      if (rows[3-r]) begin
        for (int c = 0; c < 4; c++) begin
          if (pressed[r*4+c]) columns[3-c] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cnt);
    repeat (cnt) @(negedge clk);
    #1;
  endtask

  task automatic wait_strobe(input int max, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < max) begin
      tick(1);
      cyc++;
      if (strobe === 1'b1) seen = 1'b1;
    end
  endtask

  initial begin
    Rst     = 1'b1;
    pressed = 16'h0000;
    pressed[8] = 1'b1;            // R2C0 held from the start
    tick(3);
    check_eq("rst_rows", rows, 4'b1000);
    check_eq("rst_key", cur_key, 8'd0);
    check_eq("rst_strobe", strobe, 1'b0);

    // Single press R2C0: R2 sampled on edge 12, strobe D+1 edges later.
    Rst = 1'b0;
    wait_strobe(200, n, found);
    check_eq("p1_strobe_seen", found, 1'b1);
    check_eq("p1_latency", n, 29);
    check_eq("p1_key", cur_key, 8'b00101000);
    check_eq("p1_rows_frozen", rows, 4'b0010);
    tick(1);
    check_eq("p1_strobe_pulse", strobe, 1'b0);
    tick(200);
    check_eq("p1_key_held", cur_key, 8'b00101000);
    check_eq("p1_one_strobe", strobe_cnt, 1);
    pressed = 16'h0000;
    tick(D + 2);
    check_eq("p1_key_rel_edge", cur_key, 8'b00101000);
    tick(1);
    check_eq("p1_key_cleared", cur_key, 8'd0);
    check_eq("p1_rows_adv", rows, 4'b0001);

    // Bounce on R3C0 every 3 cycles: never stable long enough to accept.
    pressed[12] = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick(3);
      pressed[12] = ~pressed[12];
    end
    check_eq("bnc_no_strobe", strobe_cnt, 1);
    check_eq("bnc_no_key", cur_key, 8'd0);
    pressed[12] = 1'b1;
    wait_strobe(200, n, found);
    check_eq("bnc_strobe_seen", found, 1'b1);
    check_eq("bnc_key", cur_key, 8'b00011000);
    pressed = 16'h0000;
    tick(D + 3);
    check_eq("bnc_key_cleared", cur_key, 8'd0);
    check_eq("bnc_strobe_cnt", strobe_cnt, 2);

    // Ghost: R1C1 + R1C2 is never one-hot, so scanning keeps rotating.
    pressed[5] = 1'b1;
    pressed[6] = 1'b1;
    v = rows;
    n = 0;
    while (rows == v && n < 12) begin
      tick(1);
      n++;
    end
    check_eq("gst_rows_moving", (rows != v), 1'b1);
    for (int k = 0; k < 8; k++) begin
      v = rows;
      n = 0;
      while (rows == v && n < 12) begin
        tick(1);
        n++;
      end
      check_eq("gst_period", n, 4);
      check_eq("gst_next_row", rows, {v[0], v[3:1]});
    end
    check_eq("gst_no_key", cur_key, 8'd0);
    check_eq("gst_no_strobe", strobe_cnt, 2);

    // Rollover: R0C1 held, R0C2 added, R0C1 released.
    pressed = 16'h0000;
    tick(10);
    pressed[1] = 1'b1;
    wait_strobe(200, n, found);
    check_eq("rol_strobe_seen", found, 1'b1);
    check_eq("rol_key", cur_key, 8'b10000100);
    pressed[2] = 1'b1;
    tick(30);
    check_eq("rol_key_both", cur_key, 8'b10000100);
    pressed[1] = 1'b0;
    tick(40);
    check_eq("rol_key_second", cur_key, 8'b10000100);
    check_eq("rol_no_2nd_strobe", strobe_cnt, 3);
    pressed[2] = 1'b0;
    tick(D + 2);
    check_eq("rol_key_rel_edge", cur_key, 8'b10000100);
    tick(1);
    check_eq("rol_key_cleared", cur_key, 8'd0);

    // Reset while R1C0 is held; re-press is recognised after R1 is scanned again.
    pressed[4] = 1'b1;
    wait_strobe(200, n, found);
    check_eq("rh_strobe_seen", found, 1'b1);
    check_eq("rh_key", cur_key, 8'b01001000);
    tick(5);
    Rst = 1'b1;
    #1;
    check_eq("rh_rst_strobe", strobe, 1'b0);
    check_eq("rh_rst_key", cur_key, 8'd0);
    check_eq("rh_rst_rows", rows, 4'b1000);
    tick(2);
    Rst = 1'b0;
    wait_strobe(200, n, found);
    check_eq("rh_restrobe_seen", found, 1'b1);
    check_eq("rh_latency", n, 25);
    check_eq("rh_rekey", cur_key, 8'b01001000);
    tick(2);
    check_eq("rh_strobe_total", strobe_cnt, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
